// File: rtl/signal_monitor.sv
// signal_monitor: measures rise-to-rise period and high time of an asynchronous square wave and tracks frequency lock.
// Define SIGNAL_MONITOR_DUTY_EN to add high-time measurement and duty-cycle checking.
module signal_monitor #(
  parameter int NOMINAL    = 4096,
  parameter int TOL        = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic        clock,
  input  logic        i_reset_n,
  input  logic        i_signal,
  input  logic        i_clear,
  output logic [12:0] o_period,
  output logic [12:0] o_high,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_err_period,
  output logic        o_err_duty,
  output logic        o_timeout
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [12:0]   SAT  = 13'h1fff;
  localparam logic [13:0]   NOM  = 14'(NOMINAL);
  localparam logic [13:0]   TOLW = 14'(TOL);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_COUNT);
  logic          s1_q, s2_q, hist_q;
  logic [1:0]    rdy_q, rdy_d;
  logic          armed_q, armed_d;
  logic [1:0]    state_q, state_d;
  logic [12:0]   per_cnt_q, per_cnt_d;
  logic [12:0]   period_q, period_d;
  logic          upd_q, upd_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          errp_q, errp_d;
  logic          timeout_q, timeout_d;
  logic          rise, active, capture, per_bad, duty_bad;
  logic [13:0]   pdiff;
  // A rise only counts once the synchronizer has shown a genuine low after reset,
  // so a wave that is already high at reset release cannot start a partial period.
  assign rise    = s2_q & ~hist_q & armed_q;
  assign active  = (state_q == MEASURE) || (state_q == TRACK);
  assign capture = rise & active;
  always_comb begin
    rdy_d     = {rdy_q[0], 1'b1};
    armed_d   = armed_q | (rdy_q[1] & ~s2_q);
    per_cnt_d = rise ? 13'd1 : (per_cnt_q == SAT) ? per_cnt_q : per_cnt_q + 13'd1;
    state_d   = rise ? (active ? TRACK : MEASURE) :
                (active && per_cnt_q == SAT) ? TIMEOUT : state_q;
    timeout_d = state_d == TIMEOUT;
    period_d  = capture ? per_cnt_q : period_q;
    upd_d     = capture;
    valid_d   = upd_q;
    pdiff     = ({1'b0, period_q} >= NOM) ? {1'b0, period_q} - NOM : NOM - {1'b0, period_q};
    per_bad   = pdiff > TOLW;
    lock_d    = (state_d == TIMEOUT) ? '0 :
                !upd_q ? lock_q :
                (per_bad || duty_bad) ? '0 :
                (lock_q == LMAX) ? lock_q : lock_q + LW'(1);
    errp_d    = (upd_q && per_bad) || (errp_q && !i_clear);
  end
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      hist_q    <= 1'b0;
      rdy_q     <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      per_cnt_q <= '0;
      period_q  <= '0;
      upd_q     <= 1'b0;
      valid_q   <= 1'b0;
      lock_q    <= '0;
      errp_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= i_signal;
      s2_q      <= s1_q;
      hist_q    <= s2_q;
      rdy_q     <= rdy_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      upd_q     <= upd_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      errp_q    <= errp_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef SIGNAL_MONITOR_DUTY_EN
  logic        fall;
  logic [12:0] high_cnt_q, high_cnt_d, high_lat_q, high_lat_d, high_q, high_d;
  logic        errd_q, errd_d;
  logic [14:0] h2, p15, ddiff;
  assign fall = ~s2_q & hist_q;
  always_comb begin
    high_cnt_d = rise ? 13'd1 : (s2_q && high_cnt_q != SAT) ? high_cnt_q + 13'd1 : high_cnt_q;
    high_lat_d = (fall && active) ? high_cnt_q : high_lat_q;
    high_d     = capture ? high_lat_q : high_q;
    h2         = {1'b0, high_q, 1'b0};
    p15        = {2'b00, period_q};
    ddiff      = (h2 >= p15) ? h2 - p15 : p15 - h2;
    duty_bad   = ddiff > 15'(2 * TOL);
    errd_d     = (upd_q && duty_bad) || (errd_q && !i_clear);
  end
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      high_cnt_q <= '0;
      high_lat_q <= '0;
      high_q     <= '0;
      errd_q     <= 1'b0;
    end else begin
      high_cnt_q <= high_cnt_d;
      high_lat_q <= high_lat_d;
      high_q     <= high_d;
      errd_q     <= errd_d;
    end
  end
  assign o_high     = high_q;
  assign o_err_duty = errd_q;
`else
  assign duty_bad   = 1'b0;
  assign o_high     = '0;
  assign o_err_duty = 1'b0;
`endif
  assign o_period     = period_q;
  assign o_valid      = valid_q;
  assign o_locked     = lock_q == LMAX;
  assign o_err_period = errp_q;
  assign o_timeout    = timeout_q;
endmodule

// File: tb/tb_signal_monitor.sv
// tb_signal_monitor: table-driven periods plus directed timeout, clear and reset sequences for signal_monitor.
module tb_signal_monitor;
`ifdef SIGNAL_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif
  localparam int H2  = DUTY ? 2048 : 0;
  localparam int H21 = DUTY ? 2100 : 0;
  localparam int HR  = DUTY ? 100 : 0;
  logic        clock = 1'b0, i_reset_n = 1'b0, i_signal = 1'b0, i_clear = 1'b0;
  logic [12:0] o_period, o_high;
  logic        o_valid, o_locked, o_err_period, o_err_duty, o_timeout;
  int errors = 0, checks = 0, vcount = 0, vc0 = 0;
  typedef struct {
    int p, h, e_period, e_high, e_vc, e_locked, e_errp, e_errd;
  } vec_t;
  vec_t tv[16];

  signal_monitor dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_signal(i_signal), .i_clear(i_clear),
    .o_period(o_period), .o_high(o_high), .o_valid(o_valid), .o_locked(o_locked),
    .o_err_period(o_err_period), .o_err_duty(o_err_duty), .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (o_valid) vcount <= vcount + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Each vector starts with a rise; checks 8 cycles later see the capture of the previous period.
  task automatic run_vec(input int i);
    i_signal = 1'b1;
    repeat (8) @(negedge clock);
    check($sformatf("v%0d period", i), int'(o_period), tv[i].e_period);
    check($sformatf("v%0d high", i), int'(o_high), tv[i].e_high);
    check($sformatf("v%0d valid_count", i), vcount, tv[i].e_vc);
    check($sformatf("v%0d locked", i), int'(o_locked), tv[i].e_locked);
    check($sformatf("v%0d err_period", i), int'(o_err_period), tv[i].e_errp);
    check($sformatf("v%0d err_duty", i), int'(o_err_duty), tv[i].e_errd);
    repeat (tv[i].h - 8) @(negedge clock);
    i_signal = 1'b0;
    repeat (tv[i].p - tv[i].h) @(negedge clock);
  endtask

  initial begin
    tv[0]  = '{4096, 2048, 0,    0,   0,  0, 0, 0};
    tv[1]  = '{4096, 2048, 4096, H2,  1,  0, 0, 0};
    tv[2]  = '{4096, 2048, 4096, H2,  2,  0, 0, 0};
    tv[3]  = '{4096, 2048, 4096, H2,  3,  0, 0, 0};
    tv[4]  = '{4096, 2048, 4096, H2,  4,  1, 0, 0};
    tv[5]  = '{4096, 2048, 4096, H2,  5,  1, 0, 0};
    tv[6]  = '{4110, 2048, 4096, H2,  6,  1, 0, 0};
    tv[7]  = '{4096, 2048, 4110, H2,  7,  0, 1, 0};
    tv[8]  = '{4096, 2048, 4096, H2,  8,  0, 1, 0};
    tv[9]  = '{4096, 2048, 4096, H2,  9,  0, 1, 0};
    tv[10] = '{4096, 2048, 4096, H2,  10, 0, 1, 0};
    tv[11] = '{4096, 2048, 4096, H2,  11, 1, 1, 0};
    tv[12] = '{4096, 2100, 4096, H21, 13, 0, 0, int'(DUTY)};
    tv[13] = '{4096, 2100, 4096, H21, 14, 0, 0, int'(DUTY)};
    tv[14] = '{4096, 2100, 4096, H21, 15, 0, 0, int'(DUTY)};
    tv[15] = '{4096, 2100, 4096, H21, 16, DUTY ? 0 : 1, 0, int'(DUTY)};
    repeat (3) @(negedge clock);
    check("reset outputs", int'({o_period, o_high, o_valid, o_locked, o_err_period, o_err_duty, o_timeout}), 0);
    i_reset_n = 1'b1;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 12; i++) run_vec(i);
    i_clear = 1'b1;
    @(negedge clock);
    i_clear = 1'b0;
    check("clear err_period", int'(o_err_period), 0);
    check("clear locked kept", int'(o_locked), 1);
    // Timeout: one rise, then the wave stops low.
    i_signal = 1'b1;
    for (int c = 1; c <= 9000; c++) begin
      @(negedge clock);
      if (c == 2048) i_signal = 1'b0;
      if (c == 3) check("valid latency edge3", int'(o_valid), 0);
      if (c == 4) check("valid latency edge4", int'(o_valid), 1);
      if (c == 5) check("valid pulse width", int'(o_valid), 0);
      if (c == 8193) begin
        check("timeout before 8191", int'(o_timeout), 0);
        check("locked before timeout", int'(o_locked), 1);
      end
      if (c == 8194) begin
        check("timeout at 8191", int'(o_timeout), 1);
        check("locked cleared by timeout", int'(o_locked), 0);
      end
    end
    vc0 = vcount;
    i_signal = 1'b1;
    repeat (12) @(negedge clock);
    check("timeout cleared by rise", int'(o_timeout), 0);
    check("no valid on timeout exit", vcount, vc0);
    repeat (2088) @(negedge clock);
    i_signal = 1'b0;
    repeat (1996) @(negedge clock);
    for (int i = 12; i < 16; i++) run_vec(i);
    // Asynchronous reset in the middle of a high phase.
    i_signal = 1'b1;
    repeat (50) @(negedge clock);
    #2 i_reset_n = 1'b0;
    #1 check("async reset outputs", int'({o_period, o_high, o_valid, o_locked, o_err_period, o_err_duty, o_timeout}), 0);
    repeat (3) @(negedge clock);
    i_reset_n = 1'b1;
    vc0 = vcount;
    repeat (100) @(negedge clock);
    i_signal = 1'b0;
    repeat (200) @(negedge clock);
    i_signal = 1'b1;
    repeat (100) @(negedge clock);
    i_signal = 1'b0;
    repeat (200) @(negedge clock);
    check("no valid before second rise", vcount, vc0);
    i_signal = 1'b1;
    i_clear = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 4) begin
        check("post-reset valid", int'(o_valid), 1);
        check("error set beats clear", int'(o_err_period), 1);
        i_clear = 1'b0;
      end
    end
    check("post-reset period", int'(o_period), 300);
    check("post-reset high", int'(o_high), HR);
    check("post-reset locked", int'(o_locked), 0);
    check("post-reset err_duty", int'(o_err_duty), int'(DUTY));
    check("post-reset valid_count", vcount, vc0 + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/signal_monitor.md
SIGNAL_MONITOR -- requirements
Module: signal_monitor

Interface
REQ-001 SHALL have parameter NOMINAL, default 4096, expected period of i_signal in clock cycles (20.48 MHz / 5 kHz).
REQ-002 SHALL have parameter TOL, default 8, allowed +/- deviation in cycles for period and high time.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, consecutive in-tolerance periods required for lock.
REQ-004 SHALL have port clock  input  1  single system clock; all flops on posedge.
REQ-005 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_signal  input  1  square wave from the divider stage, asynchronous to clock.
REQ-007 SHALL have port i_clear  input  1  synchronous clear of sticky error flags.
REQ-008 SHALL have port o_period  output  13  last measured rise-to-rise period in cycles.
REQ-009 SHALL have port o_high  output  13  last measured high time in cycles.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse when o_period/o_high update.
REQ-011 SHALL have port o_locked  output  1  frequency lock indicator.
REQ-012 SHALL have port o_err_period  output  1  sticky out-of-tolerance period flag.
REQ-013 SHALL have port o_err_duty  output  1  sticky duty-cycle error flag.
REQ-014 SHALL have port o_timeout  output  1  no rising edge for 8191 cycles.

Function
REQ-015 SHALL pass i_signal through a 2-flop synchronizer plus one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-016 SHALL count cycles in a 13-bit period counter: loaded to 1 on rise, +1 otherwise, saturating at 8191.
REQ-017 SHALL count high time in a 13-bit counter: loaded to 1 on rise, +1 while synchronized signal high, held while low, saturating at 8191.
REQ-018 SHALL implement FSM states IDLE, MEASURE, TRACK, TIMEOUT.
REQ-019 IDLE -> MEASURE on first rise; MEASURE -> TRACK on next rise; TRACK -> TRACK on rise; MEASURE/TRACK -> TIMEOUT when period counter reaches 8191; TIMEOUT -> MEASURE on rise.
REQ-020 SHALL, on rise in TRACK or MEASURE (not IDLE/TIMEOUT), register o_period <= period counter, o_high <= high-time latched at last fall, and pulse o_valid next cycle.
REQ-021 o_valid SHALL assert exactly 4 clock edges after the first edge that samples i_signal high.
REQ-022 Period in tolerance SHALL mean |o_period - NOMINAL| <= TOL (unsigned compare on 14-bit extended values, no wrap).
REQ-023 SHALL increment a lock counter (saturating at LOCK_COUNT) per in-tolerance period; o_locked = 1 when counter == LOCK_COUNT.
REQ-024 An out-of-tolerance period SHALL clear lock counter and o_locked in the same cycle o_valid asserts, and set o_err_period.
REQ-025 Entering TIMEOUT SHALL set o_timeout, clear o_locked and lock counter; leaving TIMEOUT SHALL clear o_timeout.
REQ-026 i_clear SHALL clear o_err_period and o_err_duty; if a new error coincides with i_clear, set SHALL win.
REQ-027 A fall with no preceding rise since IDLE/TIMEOUT SHALL be ignored.

Reset
REQ-028 i_reset_n low SHALL asynchronously force FSM to IDLE, all counters, synchronizer flops and all outputs to 0.
REQ-029 Reset deassertion mid-waveform SHALL require a fresh rise before any measurement; no o_valid from a partial period.

Configuration
REQ-030 Macro SIGNAL_MONITOR_DUTY_EN defined: on each o_valid, |2*o_high - o_period| > 2*TOL SHALL set o_err_duty and break lock as REQ-024.
REQ-031 Macro SIGNAL_MONITOR_DUTY_EN undefined: high-time counter and duty compare SHALL be absent; o_high and o_err_duty tied 0; ports unchanged.

Verification
REQ-032 Reset, then 6 periods of 4096 cycles, 2048 high -> o_period=4096, o_high=2048, o_valid 5 pulses, o_locked=1 after 4th pulse.
REQ-033 Locked, one period of 4110 -> o_err_period=1, o_locked=0; then 4 periods of 4096 -> o_locked=1, o_err_period stays 1 until i_clear.
REQ-034 Locked, i_signal held low 9000 cycles -> o_timeout=1 at 8191 cycles after last rise, o_locked=0; next rise clears o_timeout, no o_valid on that rise.
REQ-035 With SIGNAL_MONITOR_DUTY_EN, periods 4096 with high 2100 -> o_err_duty=1, o_locked=0; without macro -> o_err_duty=0, o_locked=1.
REQ-036 i_reset_n pulsed low mid-high-phase -> all outputs 0 immediately; first o_valid only after two rises post-reset.
